retire_trace_fifo: RTL and testbench



---
 rtl/retire_trace_pkg.sv | 35 +++
 rtl/retire_trace_compact.sv | 30 +++
 rtl/retire_trace_fifo.sv | 163 ++++++++++++++++
 tb/tb_retire_trace_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
// ============================================================================
// retire_trace_pkg : shared constants and entry-layout helpers for the retire trace FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

package retire_trace_pkg;

    localparam int REG_IDX_W = 5;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry layout, LSB first: data | reg | lane | stamp (stamp only when enabled)
    function automatic int entry_reg_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int entry_lane_lsb(input int data_w);
        return data_w + REG_IDX_W;
    endfunction

    function automatic int entry_stamp_lsb(input int data_w, input int lane_bits);
        return data_w + REG_IDX_W + lane_bits;
    endfunction

    function automatic int entry_w(input int data_w, input int lane_bits,
                                   input bit stamp_en, input int stamp_w);
        return entry_stamp_lsb(data_w, lane_bits) + (stamp_en ? stamp_w : 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/retire_trace_compact.sv
// ============================================================================
// retire_trace_compact : prefix-sum of the eligible-lane vector (slot offset per lane, total)
// Rev 1.0
// ============================================================================
`default_nettype none

module retire_trace_compact #(
    parameter int NUM_LANES = 2,
    parameter int OFS_W     = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]       elig,
    output logic [NUM_LANES*OFS_W-1:0] offset,
    output logic [OFS_W-1:0]           total
);

    logic [OFS_W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            offset[i*OFS_W +: OFS_W] = acc;
            acc = acc + OFS_W'(elig[i]);
        end
        total = acc;
    end

endmodule

`default_nettype wire

// File: rtl/retire_trace_fifo.sv
// ============================================================================
// retire_trace_fifo : multi-lane write-back capture buffer with FWFT single-pop read port
// Optional RETIRE_TRACE_TIMESTAMP_EN: per-entry cycle stamp and rd_stamp output
// Rev 1.0
// ============================================================================
`default_nettype none

module retire_trace_fifo
    import retire_trace_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int STAMP_W   = 16
) (
    input  logic                           hz1_clk,
    input  logic                           n_rst,
    input  logic [NUM_LANES-1:0]           wr_en,
    input  logic [NUM_LANES*REG_IDX_W-1:0] wr_reg,
    input  logic [NUM_LANES*DATA_W-1:0]    wr_data,
    input  logic                           filter_x0,
    input  logic                           freeze,
    input  logic                           clear,
    input  logic                           rd_ready,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic [REG_IDX_W-1:0]           rd_reg,
    output logic [lane_w(NUM_LANES)-1:0]   rd_lane,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    ,
    output logic [STAMP_W-1:0]             rd_stamp
`endif
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int LANE_W   = lane_w(NUM_LANES);
    localparam int OFS_W    = $clog2(NUM_LANES + 1);
    localparam int REG_LSB  = entry_reg_lsb(DATA_W);
    localparam int LANE_LSB = entry_lane_lsb(DATA_W);
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    localparam bit STAMP_EN  = 1'b1;
    localparam int STAMP_LSB = entry_stamp_lsb(DATA_W, LANE_W);
`else
    localparam bit STAMP_EN  = 1'b0;
`endif
    localparam int ENTRY_W  = entry_w(DATA_W, LANE_W, STAMP_EN, STAMP_W);

    logic [PTR_W-1:0]           r_head;
    logic [PTR_W-1:0]           r_tail;
    logic [CNT_W-1:0]           r_count;
    logic                       r_overflow;
    logic [ENTRY_W-1:0]         mem [DEPTH];

    logic [NUM_LANES-1:0]       w_elig;
    logic [NUM_LANES-1:0]       w_accept;
    logic [NUM_LANES*OFS_W-1:0] w_ofs;
    logic [OFS_W-1:0]           w_total;
    logic [ENTRY_W-1:0]         w_entry [NUM_LANES];
    logic [ENTRY_W-1:0]         w_head;
    logic                       w_empty;
    logic                       w_pop;
    logic [CNT_W-1:0]           w_free;
    logic [CNT_W-1:0]           w_acc_n;
    logic                       w_drop;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0]         r_stamp;
`endif

    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & rd_ready;
    // A slot vacated by this cycle's pop is immediately reusable by a push
    assign w_free  = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
    assign w_drop  = CNT_W'(w_total) > w_free;
    assign w_acc_n = w_drop ? w_free : CNT_W'(w_total);

    retire_trace_compact #(
        .NUM_LANES (NUM_LANES),
        .OFS_W     (OFS_W)
    ) u_compact (
        .elig   (w_elig),
        .offset (w_ofs),
        .total  (w_total)
    );

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign w_elig[i] = wr_en[i] & ~freeze
                         & ~(filter_x0 & (wr_reg[i*REG_IDX_W +: REG_IDX_W] == '0));
        assign w_accept[i] = w_elig[i] & (CNT_W'(w_ofs[i*OFS_W +: OFS_W]) < w_free);
`ifdef RETIRE_TRACE_TIMESTAMP_EN
        assign w_entry[i] = {r_stamp, LANE_W'(i), wr_reg[i*REG_IDX_W +: REG_IDX_W],
                             wr_data[i*DATA_W +: DATA_W]};
`else
        assign w_entry[i] = {LANE_W'(i), wr_reg[i*REG_IDX_W +: REG_IDX_W],
                             wr_data[i*DATA_W +: DATA_W]};
`endif
    end

    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_acc_n);
            r_count <= r_count + w_acc_n - CNT_W'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stamp <= '0;
        end else if (clear) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
        end
    end
`endif

    // Storage carries no reset; only entries between head and tail are ever observed
    always_ff @(posedge hz1_clk) begin
        if (n_rst && !clear) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_accept[i]) begin
                    mem[r_tail + PTR_W'(w_ofs[i*OFS_W +: OFS_W])] <= w_entry[i];
                end
            end
        end
    end

    assign w_head   = mem[r_head];
    assign rd_valid = ~w_empty;
    assign rd_data  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign rd_reg   = w_empty ? '0 : w_head[REG_LSB +: REG_IDX_W];
    assign rd_lane  = w_empty ? '0 : w_head[LANE_LSB +: LANE_W];
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    assign rd_stamp = w_empty ? '0 : w_head[STAMP_LSB +: STAMP_W];
`endif
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_retire_trace_fifo.sv
// ============================================================================
// tb_retire_trace_fifo : directed + random stimulus against a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_retire_trace_fifo;

    localparam int NL    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic [4:0]    r;
        logic          l;
    } ent_t;

    logic             hz1_clk = 1'b0;
    logic             n_rst   = 1'b0;
    logic [NL-1:0]    wr_en;
    logic [NL*5-1:0]  wr_reg;
    logic [NL*DW-1:0] wr_data;
    logic             filter_x0, freeze, clear, rd_ready;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
    logic [4:0]       rd_reg;
    logic [0:0]       rd_lane;
    logic [4:0]       count;
    logic             full, empty, overflow;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [15:0]      rd_stamp;
`endif

    ent_t m_q[$];
    logic m_ovf;
    int   total = 0;
    int   bad   = 0;

    always #5 hz1_clk = ~hz1_clk;

    retire_trace_fifo #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(DEPTH), .STAMP_W(16)) dut (
        .hz1_clk   (hz1_clk),
        .n_rst     (n_rst),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .filter_x0 (filter_x0),
        .freeze    (freeze),
        .clear     (clear),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_reg    (rd_reg),
        .rd_lane   (rd_lane),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef RETIRE_TRACE_TIMESTAMP_EN
        ,
        .rd_stamp  (rd_stamp)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic v;
        v = (m_q.size() != 0);
        chk({tag, ":valid"}, rd_valid, v);
        chk({tag, ":data"},  rd_data,  v ? m_q[0].d : 32'd0);
        chk({tag, ":reg"},   rd_reg,   v ? m_q[0].r : 5'd0);
        chk({tag, ":lane"},  rd_lane,  v ? m_q[0].l : 1'b0);
        chk({tag, ":count"}, count,    m_q.size());
        chk({tag, ":full"},  full,     m_q.size() == DEPTH);
        chk({tag, ":empty"}, empty,    !v);
        chk({tag, ":ovf"},   overflow, m_ovf);
    endtask

    // Reference: pop first, then append eligible lanes in ascending order while room remains
    task automatic model_update();
        ent_t e;
        if (clear) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd_ready && m_q.size() > 0) e = m_q.pop_front();
            for (int i = 0; i < NL; i++) begin
                if (wr_en[i] && !freeze && !(filter_x0 && wr_reg[i*5 +: 5] == 5'd0)) begin
                    if (m_q.size() < DEPTH) begin
                        e.d = wr_data[i*DW +: DW];
                        e.r = wr_reg[i*5 +: 5];
                        e.l = i[0];
                        m_q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input string tag);
        check_state(tag);
        model_update();
        @(posedge hz1_clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_reg = '0; wr_data = '0;
        filter_x0 = 0; freeze = 0; clear = 0; rd_ready = 0;
    endtask

    task automatic set_lane(input int i, input logic en, input logic [4:0] r, input logic [DW-1:0] d);
        wr_en[i]           = en;
        wr_reg[i*5 +: 5]   = r;
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic do_clear();
        idle(); clear = 1; step("clear"); idle();
    endtask

    initial begin
        idle();
        m_ovf = 1'b0;
        n_rst = 0;
        repeat (2) @(posedge hz1_clk);
        #1;
        check_state("reset");
        n_rst = 1;

        // Single push, visible next cycle
        set_lane(0, 1, 5'd3, 32'h0000_00AA);
        step("push_aa");
        idle();
        chk("aa_valid", rd_valid, 1); chk("aa_reg", rd_reg, 3);
        chk("aa_data", rd_data, 32'hAA); chk("aa_lane", rd_lane, 0); chk("aa_count", count, 1);
        rd_ready = 1; step("drain_aa"); idle();

        // Two lanes in one cycle, popped in lane order
        set_lane(0, 1, 5'd1, 32'h11); set_lane(1, 1, 5'd2, 32'h22); rd_ready = 1;
        step("push_two");
        wr_en = '0;
        chk("two_first", rd_data, 32'h11); chk("two_first_lane", rd_lane, 0);
        step("pop_first");
        chk("two_second", rd_data, 32'h22); chk("two_second_lane", rd_lane, 1);
        step("pop_second");
        chk("two_empty", empty, 1);
        idle();

        // Fill to 15, then two lanes with no pop: one accepted, one dropped
        for (int k = 0; k < 15; k++) begin
            set_lane(0, 1, 5'($urandom_range(1, 31)), $urandom);
            step("fill");
        end
        idle();
        chk("fill_count15", count, 15);
        set_lane(0, 1, 5'd7, 32'hC0DE_0000); set_lane(1, 1, 5'd8, 32'hC0DE_0001);
        step("push_at15");
        idle();
        chk("ovf_count", count, 16); chk("ovf_full", full, 1); chk("ovf_flag", overflow, 1);
        rd_ready = 1; step("pop_to15"); idle();
        set_lane(0, 1, 5'd9, 32'hBEEF_0000); set_lane(1, 1, 5'd10, 32'hBEEF_0001); rd_ready = 1;
        step("push_pop_at15");
        idle();
        chk("pp_count", count, 16); chk("pp_ovf", overflow, 1);
        do_clear();

        // x0 filter and freeze
        filter_x0 = 1;
        set_lane(0, 1, 5'd0, 32'h0BAD); set_lane(1, 1, 5'd5, 32'h0055);
        step("filter");
        chk("filt_count", count, 1); chk("filt_lane", rd_lane, 1); chk("filt_reg", rd_reg, 5);
        freeze = 1;
        step("freeze");
        chk("freeze_count", count, 1);
        do_clear();

        // Single-lane pushes interleaved with pops, crossing pointer wrap
        for (int k = 0; k < 40; k++) begin
            set_lane(0, 1, 5'($urandom_range(0, 31)), $urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            step("wrap");
            chk("wrap_bound", count <= DEPTH, 1);
        end
        idle();

        // Fully random traffic
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < NL; i++)
                set_lane(i, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            rd_ready  = ($urandom_range(0, 2) == 0);
            filter_x0 = ($urandom_range(0, 3) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 31) == 0);
            step("rand");
        end
        idle();

        // clear beats a simultaneous push and pop
        for (int k = 0; k < 9; k++) begin
            set_lane(0, 1, 5'd1, 32'(k)); set_lane(1, 1, 5'd2, 32'(k + 100));
            step("prefill");
        end
        chk("pre_clear_ovf", overflow, 1);
        clear = 1; rd_ready = 1;
        step("clear_push_pop");
        idle();
        chk("clr_count", count, 0); chk("clr_empty", empty, 1); chk("clr_ovf", overflow, 0);

        // Asynchronous reset mid-stream
        set_lane(0, 1, 5'd4, 32'h4444); set_lane(1, 1, 5'd6, 32'h6666);
        step("pre_rst1");
        step("pre_rst2");
        idle();
        #3;
        n_rst = 0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        chk("arst_valid", rd_valid, 0); chk("arst_data", rd_data, 0);
        chk("arst_count", count, 0); chk("arst_empty", empty, 1);
        @(posedge hz1_clk);
        #1;
        n_rst = 1;
        check_state("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
